// File: rtl/cmp_seq_chain_pkg.sv
// Shared definitions for the sequential chunked comparator: FSM encoding and chunk width.
package cmp_seq_chain_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CHUNK_W = 2;

endpackage

// File: rtl/cmp_seq_chain_cmp2bit.sv
// Combinational 2-bit unsigned magnitude comparator with one-hot eq/gt/lt outputs.
module cmp2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_chain.sv
// Sequential unsigned comparator: walks A and B two bits per cycle from the MSB chunk,
// stopping at the first differing chunk and reporting equal/more/less with a done pulse.
module cmp_seq_chain
    import cmp_seq_chain_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             more,
    output logic             less
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t               state;
    logic [WIDTH-1:0]     a_lat;
    logic [WIDTH-1:0]     b_lat;
    logic [IDX_W-1:0]     idx;
    logic [CHUNK_W-1:0]   a_chunk;
    logic [CHUNK_W-1:0]   b_chunk;
    logic                 chunk_eq;
    logic                 chunk_gt;
    logic                 chunk_lt;

    assign a_chunk = a_lat[int'(idx)*CHUNK_W +: CHUNK_W];
    assign b_chunk = b_lat[int'(idx)*CHUNK_W +: CHUNK_W];

    cmp2bit u_cmp2bit (
        .a  (a_chunk),
        .b  (b_chunk),
        .eq (chunk_eq),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_lat <= '0;
            b_lat <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            equal <= 1'b0;
            more  <= 1'b0;
            less  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= A;
                        b_lat <= B;
                        idx   <= IDX_W'(NCHUNK - 1);
                        equal <= 1'b0;
                        more  <= 1'b0;
                        less  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The first unequal chunk from the MSB side decides the whole magnitude.
                    if (!chunk_eq) begin
                        more  <= chunk_gt;
                        less  <= chunk_lt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        equal <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
